// File: rtl/regfile_wb.sv
// 32x32 register file with a one-entry write-back buffer.
// Writes commit two edges after presentation; reads bypass the buffer.
module regfile_wb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        stall,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        wb_valid
);

    logic [31:0] regs [32];
    logic        buf_valid;
    logic [4:0]  buf_addr;
    logic [31:0] buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= 5'd0;
            buf_data  <= 32'd0;
        end else if (!stall) begin
            buf_valid <= we && (waddr != 5'd0);
            buf_addr  <= waddr;
            buf_data  <= wdata;
        end
    end

    // The array drains the old buffer entry on the same edge the buffer refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (!stall && buf_valid) begin
            regs[buf_addr] <= buf_data;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0) begin
            rdata1 = 32'd0;
        end else if (buf_valid && buf_addr == raddr1) begin
            rdata1 = buf_data;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0) begin
            rdata2 = 32'd0;
        end else if (buf_valid && buf_addr == raddr2) begin
            rdata2 = buf_data;
        end
    end

    assign wb_valid = buf_valid;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus pushes expected outputs,
// a monitor pops and compares them on every falling edge.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_valid;

    int total = 0;
    int bad = 0;

    string       q_name [$];
    logic [64:0] q_exp  [$];

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .stall    (stall),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .wb_valid (wb_valid)
    );

    // Inputs change 1ns after a rising edge; the expectation describes
    // the outputs seen at the following falling edge.
    task automatic step(
        input string       name,
        input logic        w,
        input logic [4:0]  wa,
        input logic [31:0] wd,
        input logic        st,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [31:0] e1,
        input logic [31:0] e2,
        input logic        ev
    );
        @(posedge clk);
        #1;
        we = w;
        waddr = wa;
        wdata = wd;
        stall = st;
        raddr1 = r1;
        raddr2 = r2;
        q_name.push_back(name);
        q_exp.push_back({e1, e2, ev});
    endtask

    // Short reset pulse that lies entirely between two rising edges.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        string       nm;
        logic [64:0] ex;
        logic [64:0] act;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                nm = q_name.pop_front();
                ex = q_exp.pop_front();
                act = {rdata1, rdata2, wb_valid};
                total++;
                if (act !== ex) begin
                    bad++;
                    $display("FAIL %s: got r1=%h r2=%h v=%b want r1=%h r2=%h v=%b",
                             nm, act[64:33], act[32:1], act[0],
                             ex[64:33], ex[32:1], ex[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        we = 1'b0;
        waddr = 5'd0;
        wdata = 32'd0;
        stall = 1'b0;
        raddr1 = 5'd8;
        raddr2 = 5'd0;
        q_name.push_back("reset");
        q_exp.push_back({32'd0, 32'd0, 1'b0});
        @(negedge clk);
        @(negedge clk);

        step("pre_w8", 1, 8, 32'hDEADBEEF, 0, 8, 8, 0, 0, 0);
        rst_n = 1'b1;
        step("w8_bypass", 0, 0, 0, 0, 8, 0, 32'hDEADBEEF, 0, 1);
        step("w8_array", 0, 0, 0, 0, 8, 8, 32'hDEADBEEF, 32'hDEADBEEF, 0);

        step("z_pre", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        step("z_cap", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        step("z_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step("bb_pre", 1, 31, 1, 0, 8, 31, 32'hDEADBEEF, 0, 0);
        step("bb_e1", 1, 31, 2, 0, 8, 31, 32'hDEADBEEF, 1, 1);
        step("bb_e2", 0, 0, 0, 0, 31, 31, 2, 2, 1);
        step("bb_e3", 0, 0, 0, 0, 31, 31, 2, 2, 0);

        step("st_pre", 1, 5, 7, 0, 5, 6, 0, 0, 0);
        step("st_e1", 1, 6, 9, 1, 5, 6, 7, 0, 1);
        step("st_e2", 1, 6, 9, 1, 5, 6, 7, 0, 1);
        step("st_e3", 0, 0, 0, 0, 5, 6, 7, 0, 1);
        step("st_commit", 0, 0, 0, 0, 5, 6, 7, 0, 0);

        step("rs_pre", 1, 3, 32'h55, 0, 3, 3, 0, 0, 0);
        step("rs_e1", 0, 0, 0, 0, 3, 3, 32'h55, 32'h55, 1);
        pulse_reset();
        step("rs_after", 0, 0, 0, 0, 8, 3, 0, 0, 0);
        step("rs_after2", 1, 1, 32'hA, 0, 3, 3, 0, 0, 0);

        step("dp_b1", 1, 2, 32'hB, 0, 1, 1, 32'hA, 32'hA, 1);
        step("dp_byp", 0, 0, 0, 0, 2, 1, 32'hB, 32'hA, 1);
        step("dp_arr", 0, 0, 0, 0, 2, 1, 32'hB, 32'hA, 0);
        step("dp_same", 0, 0, 0, 0, 1, 1, 32'hA, 32'hA, 0);

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
